// File: rtl/usb_hc_axil_regs.sv
// AXI4-Lite register file for the USB 1.1 host controller: four RW control words,
// a sampled status word and a W1C interrupt-pending register driving a masked irq.
module usb_hc_axil_regs #(
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int C_S_AXI_ADDR_WIDTH = 5,
   parameter int IRQ_BITS           = 8
) (
   input  logic                              ACLK,
   input  logic                              ARESETN,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
   input  logic [2:0]                        S_AXI_AWPROT,
   input  logic                              S_AXI_AWVALID,
   output logic                              S_AXI_AWREADY,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
   input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
   input  logic                              S_AXI_WVALID,
   output logic                              S_AXI_WREADY,
   output logic [1:0]                        S_AXI_BRESP,
   output logic                              S_AXI_BVALID,
   input  logic                              S_AXI_BREADY,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
   input  logic [2:0]                        S_AXI_ARPROT,
   input  logic                              S_AXI_ARVALID,
   output logic                              S_AXI_ARREADY,
   output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
   output logic [1:0]                        S_AXI_RRESP,
   output logic                              S_AXI_RVALID,
   input  logic                              S_AXI_RREADY,
   output logic [C_S_AXI_DATA_WIDTH-1:0]     ctrl0,
   output logic [C_S_AXI_DATA_WIDTH-1:0]     ctrl1,
   output logic [C_S_AXI_DATA_WIDTH-1:0]     ctrl2,
   output logic [C_S_AXI_DATA_WIDTH-1:0]     ctrl3,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]     status_in,
   input  logic [IRQ_BITS-1:0]               irq_set,
   output logic                              irq
);
   localparam int DW = C_S_AXI_DATA_WIDTH;
   localparam int SW = C_S_AXI_DATA_WIDTH / 8;
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   function automatic logic [DW-1:0] byte_merge(input logic [DW-1:0] old_v,
                                                input logic [DW-1:0] new_v,
                                                input logic [SW-1:0] strb);
      logic [DW-1:0] r;
      r = old_v;
      for (int b = 0; b < SW; b++)
         if (strb[b]) r[8*b +: 8] = new_v[8*b +: 8];
      return r;
   endfunction

   logic                init_q;
   logic                aw_full_q, w_full_q;
   logic [2:0]          aw_idx_q;
   logic [DW-1:0]       w_data_q;
   logic [SW-1:0]       w_strb_q;
   logic                bvalid_q, rvalid_q;
   logic [1:0]          bresp_q, rresp_q;
   logic [1:0]          bresp_d, rresp_d;
   logic [DW-1:0]       rdata_q, rdata_d;
   logic [DW-1:0]       regs_q [4];
   logic [DW-1:0]       regs_d [4];
   logic [IRQ_BITS-1:0] pend_q, pend_d;
   logic [DW-1:0]       clr_mask;
   logic                irq_q;
   logic                commit, aw_hs, w_hs, ar_hs;
   logic [2:0]          ar_idx;
   logic                unused_ok;

   // Readies stay low until the first edge after reset release.
   assign S_AXI_AWREADY = init_q & ~aw_full_q;
   assign S_AXI_WREADY  = init_q & ~w_full_q;
   assign S_AXI_ARREADY = init_q & (~rvalid_q | S_AXI_RREADY);
   assign aw_hs  = S_AXI_AWVALID & S_AXI_AWREADY;
   assign w_hs   = S_AXI_WVALID & S_AXI_WREADY;
   assign ar_hs  = S_AXI_ARVALID & S_AXI_ARREADY;
   assign commit = aw_full_q & w_full_q & (~bvalid_q | S_AXI_BREADY);
   assign ar_idx = S_AXI_ARADDR[4:2];

   always_comb begin
      regs_d   = regs_q;
      clr_mask = '0;
      bresp_d  = RESP_OKAY;
      if (commit) begin
         case (aw_idx_q)
            3'd0, 3'd1, 3'd2, 3'd3:
               regs_d[aw_idx_q[1:0]] = byte_merge(regs_q[aw_idx_q[1:0]], w_data_q, w_strb_q);
            3'd4: bresp_d = RESP_OKAY;
            3'd5: clr_mask = byte_merge('0, w_data_q, w_strb_q);
            default: bresp_d = RESP_SLVERR;
         endcase
      end
      // A set pulse wins over a clear landing on the same bit.
      pend_d = (pend_q & ~clr_mask[IRQ_BITS-1:0]) | irq_set;
   end

   always_comb begin
      rdata_d = '0;
      rresp_d = RESP_OKAY;
      case (ar_idx)
         3'd0, 3'd1, 3'd2, 3'd3: rdata_d = regs_q[ar_idx[1:0]];
         3'd4: rdata_d = status_in;
         3'd5: rdata_d[IRQ_BITS-1:0] = pend_q;
         default: rresp_d = RESP_SLVERR;
      endcase
   end

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         init_q    <= 1'b0;
         aw_full_q <= 1'b0;
         w_full_q  <= 1'b0;
         aw_idx_q  <= '0;
         w_data_q  <= '0;
         w_strb_q  <= '0;
         bvalid_q  <= 1'b0;
         bresp_q   <= RESP_OKAY;
         rvalid_q  <= 1'b0;
         rresp_q   <= RESP_OKAY;
         rdata_q   <= '0;
         for (int i = 0; i < 4; i++) regs_q[i] <= '0;
         pend_q    <= '0;
         irq_q     <= 1'b0;
      end else begin
         init_q <= 1'b1;
         if (commit) begin
            aw_full_q <= 1'b0;
            w_full_q  <= 1'b0;
            bvalid_q  <= 1'b1;
            bresp_q   <= bresp_d;
         end else if (S_AXI_BREADY) begin
            bvalid_q  <= 1'b0;
         end
         if (aw_hs) begin
            aw_full_q <= 1'b1;
            aw_idx_q  <= S_AXI_AWADDR[4:2];
         end
         if (w_hs) begin
            w_full_q <= 1'b1;
            w_data_q <= S_AXI_WDATA;
            w_strb_q <= S_AXI_WSTRB;
         end
         if (ar_hs) begin
            rvalid_q <= 1'b1;
            rdata_q  <= rdata_d;
            rresp_q  <= rresp_d;
         end else if (S_AXI_RREADY) begin
            rvalid_q <= 1'b0;
         end
         regs_q <= regs_d;
         pend_q <= pend_d;
         irq_q  <= |(pend_q & regs_q[3][IRQ_BITS-1:0]);
      end
   end

   assign S_AXI_BVALID = bvalid_q;
   assign S_AXI_BRESP  = bresp_q;
   assign S_AXI_RVALID = rvalid_q;
   assign S_AXI_RRESP  = rresp_q;
   assign S_AXI_RDATA  = rdata_q;
   assign ctrl0 = regs_q[0];
   assign ctrl1 = regs_q[1];
   assign ctrl2 = regs_q[2];
   assign ctrl3 = regs_q[3];
   assign irq   = irq_q;

   assign unused_ok = &{1'b0, S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0],
                        S_AXI_ARADDR[1:0], clr_mask};
endmodule
